usb_rx_sipo: RTL and testbench
==============================

Name: usb_rx_sipo

Overview:
- Receive-path counterpart of the host PISO/transmit path. It takes the per-bit line states (J/K/SE0) produced by the speed detector and performs SYNC detection, NRZI decode, bit unstuffing, LSB-first byte assembly and EOP detection.
- Recovered bytes are pushed into the receive FIFO via its write port.
- One instance per downstream device port; it drives the SIPO_empty/serial_data_out side of the host datapath.

Parameters:
- SYNC_MIN_TRANSITIONS, 5, minimum alternating J/K samples before the closing KK that are accepted as SYNC.
- STUFF_LIMIT, 6, count of consecutive decoded 1s after which a stuffed 0 is mandatory.
- EOP_SE0_MIN, 2, minimum consecutive SE0 samples forming a valid EOP.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bit_strobe  in  1  one-cycle sample enable, once per bit period (polling clock). Line inputs are only evaluated when it is high.
- j_state  in  1  line is J.
- k_state  in  1  line is K.
- se0_state  in  1  line is SE0/idle. More than one state input high at once counts as SE0.
- w_data  out  8  byte to FIFO.
- wr_en  out  1  FIFO write strobe, one cycle per byte.
- w_last  out  1  qualifies w_data as the final byte of the packet.
- flag_full  in  1  FIFO full.
- rx_active  out  1  high from SYNC-complete until the EOP state is left.
- rx_error  out  1  one-cycle pulse on any error.
- rx_err_code  out  3  valid with rx_error: 1 = stuff, 2 = align, 3 = overflow, 4 = empty packet, 5 = pid (feature only).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, held-byte register empty. Reset mid-packet aborts without any write.
- FSM states: IDLE, SYNC, DATA, EOP, ERR. All transitions happen only on bit_strobe.
- IDLE:
  - K goes to SYNC with prev_line = K and trans_cnt = 0.
- SYNC:
  - A sample opposite to prev_line increments trans_cnt.
  - K following K with trans_cnt >= SYNC_MIN_TRANSITIONS goes to DATA and asserts rx_active. prev_line = K, ones_cnt = 0, bit_cnt = 0.
  - K following K with too few transitions, J following J, or SE0 returns to IDLE silently.
- DATA:
  - NRZI decode: decoded bit = 1 if the line equals prev_line, 0 if it differs. prev_line then updates.
  - Unstuffing: when ones_cnt == STUFF_LIMIT, the next bit must be 0 and is discarded (not counted). If it is 1, report stuff error and go to ERR.
  - Assembly: bits shift in LSB-first. bit_cnt wraps 7 to 0 on byte completion.
  - On byte completion: if a held byte exists, write it with wr_en = 1 and w_last = 0 on the cycle after the strobe. The new byte then becomes the held byte.
- Latency and last-byte marking: the last byte is written only at EOP, so w_last is exact. Byte N is written in the cycle after byte N+1 completes.
- DATA on SE0: go to EOP, se0_cnt = 1.
- EOP:
  - SE0 increments se0_cnt.
  - J with se0_cnt >= EOP_SE0_MIN ends the packet:
    - if bit_cnt != 0 (a stuffed trailing 0 is permitted), report align error and drop the held byte;
    - else if no held byte exists, report empty-packet error;
    - else write the held byte with w_last = 1.
  - In all three cases, deassert rx_active and go to IDLE.
  - K, or J with too few SE0 samples: align error, go to ERR.
- ERR: deassert rx_active and discard the held byte. Go to IDLE after EOP_SE0_MIN SE0 samples followed by J.
- Overflow: if a write is due while flag_full = 1, the byte is dropped, wr_en stays 0 and an overflow error pulses. Reception continues, so later bytes may still be written.
- Simultaneous events: an error and a write never coincide. If bit_strobe arrives on the same cycle as a pending write, the write completes and the strobe is processed normally; the write is registered.

Optional Feature:
- USB_RX_PID_CHECK_EN
- Defined: the first byte of each packet must satisfy w_data[7:4] == ~w_data[3:0]. If not, the packet is aborted with code 5 before any write, and the FSM goes to ERR.
- Undefined: no PID check, code 5 is never produced, and the logic is absent.

Decomposition:
- Shared package/includes: FSM state encoding, rx_err_code constants, and the line-state encoding (J/K/SE0). The same line-state encoding is used by the transmit path.
- One sub-module, usb_nrzi_unstuff. It holds prev_line, ones_cnt and the stuff-error check. Outputs: decoded bit, bit-valid (0 for a discarded stuffed bit) and stuff_err.

Test Plan:
- SYNC KJKJKJKK, then byte 0xA5 NRZI-encoded, SE0 SE0 J: exactly one write, w_data = 0xA5 with w_last = 1, after the J strobe; no error.
- Bytes 0xFF, 0x01 (stuffed 0 inserted after six 1s), then EOP: writes 0xFF with last = 0, then 0x01 with last = 1. rx_active is high from the closing K until EOP.
- Seven consecutive 1s in the line data: rx_error with code 1, no writes, FSM returns to IDLE after SE0 SE0 J.
- EOP after 11 data bits: code 2, zero writes for the packet.
- Three bytes with flag_full held high during the second write: writes bytes 1 and 3 (last = 1), one code 3 pulse.
- With USB_RX_PID_CHECK_EN, first byte 0x69 (valid) gives normal writes; first byte 0x66 gives code 5 and no writes.

Source files
------------

// File: rtl/usb_rx_sipo_pkg.sv
// Shared encodings for the USB receive path: line states, FSM states, error codes.
// The line-state encoding is also used by the transmit path.
package usb_rx_sipo_pkg;

    localparam int SYNC_MIN_TRANSITIONS = 5;
    localparam int STUFF_LIMIT          = 6;
    localparam int EOP_SE0_MIN          = 2;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'd0,
        LINE_J   = 2'd1,
        LINE_K   = 2'd2
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [2:0] ERR_STUFF    = 3'd1;
    localparam logic [2:0] ERR_ALIGN    = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_EMPTY    = 3'd4;
    localparam logic [2:0] ERR_PID      = 3'd5;

    // Anything other than exactly one of J or K is treated as SE0.
    function automatic line_t line_decode(input logic j, input logic k, input logic se0);
        if (j && !k && !se0)
            return LINE_J;
        else if (k && !j && !se0)
            return LINE_K;
        else
            return LINE_SE0;
    endfunction

    function automatic logic pid_ok(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]);
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer: decoded bit and valid are combinational from the current sample,
// state (prev_line, ones_cnt) advances on i_en; i_init reloads the state for a new packet.
module usb_nrzi_unstuff
    import usb_rx_sipo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_init,
    input  logic  i_en,
    input  line_t i_line,
    output logic  o_bit,
    output logic  o_bit_vld,
    output logic  o_stuff_err
);

    line_t      r_prev;
    logic [2:0] r_ones;
    logic       w_stuffed;

    assign w_stuffed   = (r_ones == 3'(STUFF_LIMIT));
    assign o_bit       = (i_line == r_prev);
    assign o_bit_vld   = !w_stuffed;
    assign o_stuff_err = w_stuffed && o_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= LINE_K;
            r_ones <= 3'd0;
        end else if (i_init) begin
            r_prev <= LINE_K;
            r_ones <= 3'd0;
        end else if (i_en) begin
            r_prev <= i_line;
            if (w_stuffed || !o_bit)
                r_ones <= 3'd0;
            else
                r_ones <= r_ones + 3'd1;
        end
    end

endmodule

// File: rtl/usb_rx_sipo.sv
// USB receive SIPO: SYNC detect, NRZI/unstuff, LSB-first assembly, EOP; one byte held back so w_last is exact.
// Optional first-byte PID check enabled by USB_RX_PID_CHECK_EN.
module usb_rx_sipo
    import usb_rx_sipo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_strobe,
    input  logic       j_state,
    input  logic       k_state,
    input  logic       se0_state,
    output logic [7:0] w_data,
    output logic       wr_en,
    output logic       w_last,
    input  logic       flag_full,
    output logic       rx_active,
    output logic       rx_error,
    output logic [2:0] rx_err_code
);

    state_t     r_state;
    line_t      r_prev;
    logic [3:0] r_trans_cnt;
    logic [1:0] r_se0_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_held;
    logic       r_held_vld;
    logic [7:0] r_w_data;
    logic       r_wr_en;
    logic       r_w_last;
    logic       r_rx_active;
    logic       r_rx_error;
    logic [2:0] r_err_code;

    line_t      w_line;
    logic       w_init;
    logic       w_nrzi_en;
    logic       w_bit;
    logic       w_bit_vld;
    logic       w_stuff_err;
    logic [7:0] w_byte;
    logic       w_pid_bad;
    logic       w_se0_enough;

    assign w_line       = line_decode(j_state, k_state, se0_state);
    assign w_init       = bit_strobe && (r_state == ST_SYNC) && (w_line == LINE_K) &&
                          (r_prev == LINE_K) && (r_trans_cnt >= 4'(SYNC_MIN_TRANSITIONS));
    assign w_nrzi_en    = bit_strobe && (r_state == ST_DATA) && (w_line != LINE_SE0);
    assign w_byte       = {w_bit, r_shift[7:1]};
    assign w_se0_enough = (r_se0_cnt >= 2'(EOP_SE0_MIN));

`ifdef USB_RX_PID_CHECK_EN
    assign w_pid_bad = !r_held_vld && !pid_ok(w_byte);
`else
    assign w_pid_bad = 1'b0;
`endif

    usb_nrzi_unstuff u_nrzi (
        .clk         (clk),
        .rst         (rst),
        .i_init      (w_init),
        .i_en        (w_nrzi_en),
        .i_line      (w_line),
        .o_bit       (w_bit),
        .o_bit_vld   (w_bit_vld),
        .o_stuff_err (w_stuff_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_prev      <= LINE_K;
            r_trans_cnt <= 4'd0;
            r_se0_cnt   <= 2'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_held      <= 8'd0;
            r_held_vld  <= 1'b0;
            r_w_data    <= 8'd0;
            r_wr_en     <= 1'b0;
            r_w_last    <= 1'b0;
            r_rx_active <= 1'b0;
            r_rx_error  <= 1'b0;
            r_err_code  <= 3'd0;
        end else begin
            r_wr_en    <= 1'b0;
            r_w_last   <= 1'b0;
            r_rx_error <= 1'b0;
            r_err_code <= 3'd0;
            if (bit_strobe) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_line == LINE_K) begin
                            r_state     <= ST_SYNC;
                            r_prev      <= LINE_K;
                            r_trans_cnt <= 4'd0;
                        end
                    end
                    ST_SYNC: begin
                        if (w_line == LINE_SE0) begin
                            r_state <= ST_IDLE;
                        end else if (w_line != r_prev) begin
                            r_prev <= w_line;
                            if (r_trans_cnt != 4'hF)
                                r_trans_cnt <= r_trans_cnt + 4'd1;
                        end else if (w_init) begin
                            r_state     <= ST_DATA;
                            r_rx_active <= 1'b1;
                            r_bit_cnt   <= 3'd0;
                            r_held_vld  <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (w_line == LINE_SE0) begin
                            r_state   <= ST_EOP;
                            r_se0_cnt <= 2'd1;
                        end else if (w_stuff_err || (w_bit_vld && r_bit_cnt == 3'd7 && w_pid_bad)) begin
                            r_state     <= ST_ERR;
                            r_rx_active <= 1'b0;
                            r_held_vld  <= 1'b0;
                            r_se0_cnt   <= 2'd0;
                            r_rx_error  <= 1'b1;
                            r_err_code  <= w_stuff_err ? ERR_STUFF : ERR_PID;
                        end else if (w_bit_vld) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                // The previous byte is released only once a newer one proves it is not last.
                                if (r_held_vld) begin
                                    if (flag_full) begin
                                        r_rx_error <= 1'b1;
                                        r_err_code <= ERR_OVERFLOW;
                                    end else begin
                                        r_wr_en  <= 1'b1;
                                        r_w_data <= r_held;
                                    end
                                end
                                r_held     <= w_byte;
                                r_held_vld <= 1'b1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (w_line == LINE_SE0) begin
                            if (r_se0_cnt != 2'd3)
                                r_se0_cnt <= r_se0_cnt + 2'd1;
                        end else if (w_line == LINE_J && w_se0_enough) begin
                            r_state     <= ST_IDLE;
                            r_rx_active <= 1'b0;
                            r_held_vld  <= 1'b0;
                            if (r_bit_cnt != 3'd0 || !r_held_vld || flag_full) begin
                                r_rx_error <= 1'b1;
                                r_err_code <= (r_bit_cnt != 3'd0) ? ERR_ALIGN :
                                              (!r_held_vld)       ? ERR_EMPTY : ERR_OVERFLOW;
                            end else begin
                                r_wr_en  <= 1'b1;
                                r_w_last <= 1'b1;
                                r_w_data <= r_held;
                            end
                        end else begin
                            r_state     <= ST_ERR;
                            r_rx_active <= 1'b0;
                            r_held_vld  <= 1'b0;
                            r_se0_cnt   <= 2'd0;
                            r_rx_error  <= 1'b1;
                            r_err_code  <= ERR_ALIGN;
                        end
                    end
                    ST_ERR: begin
                        r_rx_active <= 1'b0;
                        r_held_vld  <= 1'b0;
                        if (w_line == LINE_SE0) begin
                            if (r_se0_cnt != 2'd3)
                                r_se0_cnt <= r_se0_cnt + 2'd1;
                        end else if (w_line == LINE_J && w_se0_enough) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_se0_cnt <= 2'd0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_data      = r_w_data;
    assign wr_en       = r_wr_en;
    assign w_last      = r_w_last;
    assign rx_active   = r_rx_active;
    assign rx_error    = r_rx_error;
    assign rx_err_code = r_err_code;

endmodule

// File: tb/tb_usb_rx_sipo.sv
// Bench for usb_rx_sipo: packets are built as byte lists, line-encoded by the bench (stuffing + NRZI),
// and the expected FIFO writes / error pulses are derived from the byte list and the full-drop pattern.
module tb_usb_rx_sipo;

    localparam int L_SE0 = 0;
    localparam int L_J   = 1;
    localparam int L_K   = 2;
`ifdef USB_RX_PID_CHECK_EN
    localparam bit PID_EN = 1'b1;
`else
    localparam bit PID_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       j_state = 1'b1;
    logic       k_state = 1'b0;
    logic       se0_state = 1'b0;
    logic       flag_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_en;
    logic       w_last;
    logic       rx_active;
    logic       rx_error;
    logic [2:0] rx_err_code;

    usb_rx_sipo dut (
        .clk         (clk),
        .rst         (rst),
        .bit_strobe  (bit_strobe),
        .j_state     (j_state),
        .k_state     (k_state),
        .se0_state   (se0_state),
        .w_data      (w_data),
        .wr_en       (wr_en),
        .w_last      (w_last),
        .flag_full   (flag_full),
        .rx_active   (rx_active),
        .rx_error    (rx_error),
        .rx_err_code (rx_err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_coinc  = 0;

    int         line_q[$];
    bit         full_q[$];
    logic [7:0] pkt[$];
    bit         drop[$];
    int         exp_dat[$];
    int         exp_last[$];
    int         exp_err[$];
    int         obs_dat[$];
    int         obs_last[$];
    int         obs_err[$];
    int         enc_prev;
    int         enc_ones;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_dat.push_back(int'(w_data));
            obs_last.push_back(int'(w_last));
        end
        if (rx_error)
            obs_err.push_back(int'(rx_err_code));
        if (wr_en && rx_error)
            n_coinc++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start();
        line_q.delete(); full_q.delete();
        pkt.delete(); drop.delete();
        exp_dat.delete(); exp_last.delete(); exp_err.delete();
        obs_dat.delete(); obs_last.delete(); obs_err.delete();
        enc_prev = L_K;
        enc_ones = 0;
    endtask

    task automatic add(input int l, input bit f);
        line_q.push_back(l);
        full_q.push_back(f);
    endtask

    task automatic add_sync();
        add(L_K, 0); add(L_J, 0); add(L_K, 0); add(L_J, 0);
        add(L_K, 0); add(L_J, 0); add(L_K, 0); add(L_K, 0);
        enc_prev = L_K;
        enc_ones = 0;
    endtask

    // A 1 keeps the line, a 0 toggles it; with stuffing, a 0 is forced after six 1s.
    task automatic enc_bit(input bit b, input bit f, input bit stuff);
        if (!b) enc_prev = (enc_prev == L_J) ? L_K : L_J;
        add(enc_prev, f);
        if (stuff) begin
            enc_ones = b ? enc_ones + 1 : 0;
            if (enc_ones == 6) begin
                enc_prev = (enc_prev == L_J) ? L_K : L_J;
                add(enc_prev, 0);
                enc_ones = 0;
            end
        end
    endtask

    // flag_full is raised on the strobe at which the write of byte b-1 falls due.
    task automatic add_pkt_bytes();
        for (int b = 0; b < pkt.size(); b++)
            for (int i = 0; i < 8; i++)
                enc_bit(pkt[b][i], (i == 7) && (b >= 1) && drop[b-1], 1'b1);
    endtask

    task automatic add_eop();
        add(L_SE0, 0);
        add(L_SE0, 0);
        add(L_J, (pkt.size() > 0) ? drop[pkt.size()-1] : 1'b0);
    endtask

    task automatic build_expect();
        if (PID_EN && pkt.size() > 0 && (pkt[0][7:4] != ~pkt[0][3:0])) begin
            exp_err.push_back(5);
        end else if (pkt.size() == 0) begin
            exp_err.push_back(4);
        end else begin
            for (int b = 0; b < pkt.size(); b++) begin
                if (drop[b]) begin
                    exp_err.push_back(3);
                end else begin
                    exp_dat.push_back(int'(pkt[b]));
                    exp_last.push_back((b == pkt.size() - 1) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic play();
        for (int i = 0; i < line_q.size(); i++) begin
            @(negedge clk);
            j_state   = (line_q[i] == L_J);
            k_state   = (line_q[i] == L_K);
            se0_state = (line_q[i] == L_SE0);
            // SE0 is sometimes presented as J and K high together.
            if (line_q[i] == L_SE0 && $urandom_range(0, 1) == 1) begin
                j_state   = 1'b1;
                k_state   = 1'b1;
                se0_state = 1'b0;
            end
            flag_full  = full_q[i];
            bit_strobe = 1'b1;
            @(negedge clk);
            bit_strobe = 1'b0;
            flag_full  = 1'b0;
            repeat (3) @(negedge clk);
        end
        line_q.delete();
        full_q.delete();
    endtask

    task automatic compare(input string tag);
        check({tag, "_nwr"}, obs_dat.size(), exp_dat.size());
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            check($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
            check($sformatf("%s_last%0d", tag, i), obs_last[i], exp_last[i]);
        end
        check({tag, "_nerr"}, obs_err.size(), exp_err.size());
        for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
            check($sformatf("%s_code%0d", tag, i), obs_err[i], exp_err[i]);
    endtask

    task automatic run_packet(input string tag);
        build_expect();
        add(L_J, 0); add(L_J, 0);
        add_sync();
        add_pkt_bytes();
        add_eop();
        play();
        compare(tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_w_last", w_last, 0);
        check("rst_w_data", w_data, 0);
        check("rst_rx_active", rx_active, 0);
        check("rst_rx_error", rx_error, 0);
        check("rst_err_code", rx_err_code, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        start(); pkt = '{8'hA5}; drop = '{1'b0};
        run_packet("single_a5");

        // Two bytes with a stuffed zero, with rx_active sampled around the closing K and the EOP.
        start(); pkt = '{8'hFF, 8'h01}; drop = '{1'b0, 1'b0};
        build_expect();
        add(L_J, 0);
        add_sync();
        void'(line_q.pop_back());
        void'(full_q.pop_back());
        play();
        check("act_before_close", rx_active, 0);
        add(L_K, 0); play();
        check("act_after_close", rx_active, 1);
        add_pkt_bytes(); add(L_SE0, 0); add(L_SE0, 0); play();
        check("act_in_eop", rx_active, 1);
        add(L_J, 0); play();
        check("act_after_eop", rx_active, 0);
        compare("ff_01");

        start();
        exp_err.push_back(1);
        add(L_J, 0); add_sync();
        for (int i = 0; i < 7; i++) enc_bit(1'b1, 1'b0, 1'b0);
        add_eop(); play();
        compare("seven_ones");

        start();
        exp_err.push_back(2);
        add(L_J, 0); add_sync();
        for (int i = 0; i < 8; i++) enc_bit(((8'hA5 >> i) & 8'h01) != 0, 1'b0, 1'b1);
        enc_bit(1'b1, 1'b0, 1'b1); enc_bit(1'b0, 1'b0, 1'b1); enc_bit(1'b1, 1'b0, 1'b1);
        add_eop(); play();
        compare("eleven_bits");

        start(); pkt = '{8'hE1, 8'h22, 8'h33}; drop = '{1'b0, 1'b1, 1'b0};
        run_packet("overflow_mid");

        start(); pkt = '{8'h69, 8'h3C}; drop = '{1'b0, 1'b0};
        run_packet("pid_69");

        start(); pkt = '{8'h66, 8'h3C}; drop = '{1'b0, 1'b0};
        run_packet("pid_66");

        start();
        run_packet("empty");

        // Reset in the middle of a packet: nothing is written and all outputs clear.
        start();
        add(L_J, 0); add_sync();
        for (int i = 0; i < 12; i++) enc_bit(1'(i % 3 == 0), 1'b0, 1'b1);
        play();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_active", rx_active, 0);
        check("midrst_nwr", obs_dat.size(), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int p = 0; p < 24; p++) begin
            int n;
            start();
            n = $urandom_range(0, 4);
            for (int b = 0; b < n; b++) begin
                logic [7:0] v;
                v = 8'($urandom);
                if (b == 0 && $urandom_range(0, 3) != 0) v[7:4] = ~v[3:0];
                pkt.push_back(v);
                drop.push_back($urandom_range(0, 3) == 0);
            end
            run_packet($sformatf("rnd%0d", p));
        end

        check("no_err_with_write", n_coinc, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
